register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of all data ports.
REQ-002 Parameter ADDR_W, default 5: address width; the file holds 2**ADDR_W registers (32 by default).
REQ-003 Clk  input  1  single clock; all writes on rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset; clears every register.
REQ-005 Ard1  input  ADDR_W  read address, port 1.
REQ-006 Ard2  input  ADDR_W  read address, port 2.
REQ-007 Awr  input  ADDR_W  write address.
REQ-008 Din  input  DATA_W  write data.
REQ-009 WrEn  input  1  write enable, sampled at rising Clk.
REQ-010 Dout1  output  DATA_W  read data, port 1.
REQ-011 Dout2  output  DATA_W  read data, port 2.

Function
REQ-012 Storage SHALL be 2**ADDR_W registers of DATA_W bits each; register 0 SHALL always read as 0.
REQ-013 Reads SHALL be combinational: Dout1/Dout2 SHALL follow Ard1/Ard2 and stored contents with zero clock latency.
REQ-014 On a rising Clk with WrEn=1 and Awr!=0, register[Awr] SHALL load Din; the new value SHALL be visible on reads after that edge.
REQ-015 Writes with Awr=0 SHALL be discarded; register 0 content SHALL never change.
REQ-016 With WrEn=0, no register SHALL change at a clock edge.
REQ-017 Exactly one register SHALL be written per enabled edge; all others SHALL hold their value.
REQ-018 Both read ports SHALL be independent; Ard1=Ard2 SHALL return identical data on both ports.
REQ-019 Read-during-write to the same address, same cycle: behaviour SHALL follow REQ-027/REQ-028.
REQ-020 X or Z on Awr while WrEn=0 SHALL NOT corrupt storage.

Reset
REQ-021 Rst=1 SHALL clear all registers to 0 immediately, without waiting for Clk.
REQ-022 While Rst=1, Dout1 and Dout2 SHALL read 0 for every address, and writes SHALL be ignored.
REQ-023 Rst asserted coincident with a write edge SHALL win; the targeted register SHALL be 0.
REQ-024 After Rst deasserts, the first rising Clk with WrEn=1 SHALL write normally.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL select read-during-write forwarding.
REQ-026 The macro SHALL affect only the read path; storage and write timing SHALL be identical in both builds.
REQ-027 With REGFILE_BYPASS_EN defined: when WrEn=1, Awr!=0 and Ardn=Awr, Doutn SHALL present Din combinationally, before the edge.
REQ-028 Without REGFILE_BYPASS_EN: Doutn SHALL present the stored (old) value until the write edge.

Structure
REQ-029 Shared package/header SHALL hold DATA_W and ADDR_W defaults and the zero-register index constant (REG_ZERO = 0).
REQ-030 One sub-module, regfile_write_decoder, SHALL convert Awr/WrEn into a one-hot per-register write enable, with bit 0 forced low.
REQ-031 Storage elements SHALL be per-register flops with asynchronous clear; no RAM macro inference.

Verification
REQ-032 Reset: Rst=1 after filling all registers with 32'hFFFF_FFFF -> all reads 0 immediately, before any Clk edge.
REQ-033 Write/read: WrEn=1, Awr=5, Din=32'hF0F0_F0F0, one edge; Ard1=5, Ard2=0 -> Dout1=32'hF0F0_F0F0, Dout2=0.
REQ-034 Zero register: WrEn=1, Awr=0, Din=32'hDEAD_BEEF, one edge -> Dout1 with Ard1=0 reads 0.
REQ-035 Hold: write 32'h1234_5678 to reg 7, then WrEn=0, Din=32'hFFFF_FFFF, 3 edges -> reg 7 still 32'h1234_5678.
REQ-036 Read-during-write: reg 9=32'h1, then WrEn=1, Awr=9, Din=32'h2, Ard1=9 before edge -> Dout1=32'h2 with REGFILE_BYPASS_EN, 32'h1 without; 32'h2 after edge in both.
REQ-037 Walking pattern: write (i*32'h0101_0101) to reg i for i=1..31, then read all on both ports -> every value matches, reg 0 reads 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared constants for the register file: default geometry and the
// hard-wired zero register index.
package register_file_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/regfile_write_decoder.sv
// Write-address decoder: turns Awr/WrEn into a one-hot per-register
// write enable. Bit REG_ZERO is never set, so register 0 can never load.
module regfile_write_decoder
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0]      awr,
    input  logic                   wren,
    output logic [2**ADDR_W-1:0]   we
);

    localparam int unsigned NREG = 2**ADDR_W;

    // One-hot decode, gated by WrEn so an unknown address with WrEn low selects nothing
    always_comb begin
        we = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            we[i] = wren && (awr == ADDR_W'(i)) && (i != REG_ZERO);
        end
    end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with register 0 hard-wired to zero.
// Reads are combinational; writes happen on the rising clock edge.
// Optional macro REGFILE_BYPASS_EN forwards Din to a read port whose
// address matches an enabled, non-zero write address (read path only).
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] Ard1,
    input  logic [ADDR_W-1:0] Ard2,
    input  logic [ADDR_W-1:0] Awr,
    input  logic [DATA_W-1:0] Din,
    input  logic              WrEn,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2
);

    localparam int unsigned NREG = 2**ADDR_W;

    logic [NREG-1:0]   we;
    logic [DATA_W-1:0] regs [NREG];

    regfile_write_decoder #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .awr  (Awr),
        .wren (WrEn),
        .we   (we)
    );

    // Per-register flops with asynchronous clear; only the decoded register loads
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (we[i]) begin
                    regs[i] <= Din;
                end
            end
        end
    end

    // Read port 1: zero register, optional forwarding, forced to 0 while in reset
    always_comb begin
        Dout1 = regs[Ard1];
        if (Ard1 == ADDR_W'(REG_ZERO)) begin
            Dout1 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (WrEn && (Awr != ADDR_W'(REG_ZERO)) && (Ard1 == Awr)) begin
            Dout1 = Din;
        end
`endif
        if (Rst) begin
            Dout1 = '0;
        end
    end

    // Read port 2: identical structure to port 1, independent address
    always_comb begin
        Dout2 = regs[Ard2];
        if (Ard2 == ADDR_W'(REG_ZERO)) begin
            Dout2 = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (WrEn && (Awr != ADDR_W'(REG_ZERO)) && (Ard2 == Awr)) begin
            Dout2 = Din;
        end
`endif
        if (Rst) begin
            Dout2 = '0;
        end
    end

endmodule
